// File: rtl/decode_collect.sv
// decode_collect: gathers an opcode word and its optional source/destination
// immediates from the fetch stream into one complete instruction for execute.
module decode_collect #(
    parameter logic [15:0] RESET_PC = 16'h0000
) (
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic        fetch_valid_i,
    output logic        fetch_ready_o,
    input  logic [15:0] fetch_addr_i,
    input  logic [15:0] fetch_inst_i,
    output logic        fetch_pc_valid_o,
    output logic [15:0] fetch_pc_o,
    output logic        exe_valid_o,
    input  logic        exe_ready_i,
    output logic [15:0] exe_addr_o,
    output logic [15:0] exe_inst_o,
    output logic [15:0] exe_src_imm_o,
    output logic [15:0] exe_dst_imm_o,
    output logic        exe_src_imm_valid_o,
    output logic        exe_dst_imm_valid_o,
    input  logic        exe_branch_valid_i,
    input  logic [15:0] exe_branch_pc_i
);

    typedef enum logic [1:0] {
        START   = 2'd0,
        OPCODE  = 2'd1,
        SRC_IMM = 2'd2,
        DST_IMM = 2'd3
    } state_t;

    state_t      state;
    logic [15:0] part_inst;
    logic [15:0] part_addr;
    logic [15:0] part_src_imm;
    logic        part_has_src;
    logic        part_has_dst;
    logic        branch_pulse;
    logic [15:0] branch_pc;

    logic        word_has_src;
    logic        word_has_dst;
    logic        word_completes;
    logic        start_active;
    logic        accept;

    assign word_has_src = (fetch_inst_i[11:8] == 4'hF) && (fetch_inst_i[7:6] == 2'd2);
    assign word_has_dst = (fetch_inst_i[5:2] == 4'hF) && (fetch_inst_i[1:0] == 2'd2)
                          && (fetch_inst_i[15:12] < 4'hE);

    always_comb begin
        word_completes = 1'b0;
        case (state)
            OPCODE:  word_completes = !word_has_src && !word_has_dst;
            SRC_IMM: word_completes = !part_has_dst;
            DST_IMM: word_completes = 1'b1;
            default: word_completes = 1'b0;
        endcase
    end

    // Refuse only the word that would overwrite a stalled, unconsumed instruction.
    assign fetch_ready_o = (state != START) && !(word_completes && exe_valid_o && !exe_ready_i);
    assign accept        = fetch_valid_i && fetch_ready_o;

    // START is a live cycle only once reset has been released.
    assign start_active     = (state == START) && rst_n_i;
    assign fetch_pc_valid_o = start_active || branch_pulse;
    assign fetch_pc_o       = start_active ? RESET_PC : branch_pc;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state               <= START;
            part_inst           <= 16'h0000;
            part_addr           <= 16'h0000;
            part_src_imm        <= 16'h0000;
            part_has_src        <= 1'b0;
            part_has_dst        <= 1'b0;
            branch_pulse        <= 1'b0;
            branch_pc           <= 16'h0000;
            exe_valid_o         <= 1'b0;
            exe_addr_o          <= 16'h0000;
            exe_inst_o          <= 16'h0000;
            exe_src_imm_o       <= 16'h0000;
            exe_dst_imm_o       <= 16'h0000;
            exe_src_imm_valid_o <= 1'b0;
            exe_dst_imm_valid_o <= 1'b0;
        end else begin
            branch_pulse <= exe_branch_valid_i;
            if (exe_branch_valid_i) begin
                branch_pc <= exe_branch_pc_i;
            end

            if (exe_branch_valid_i) begin
                state       <= OPCODE;
                exe_valid_o <= 1'b0;
            end else begin
                if (exe_valid_o && exe_ready_i) begin
                    exe_valid_o <= 1'b0;
                end
                case (state)
                    START: state <= OPCODE;
                    OPCODE: if (accept) begin
                        part_inst    <= fetch_inst_i;
                        part_addr    <= fetch_addr_i;
                        part_has_src <= word_has_src;
                        part_has_dst <= word_has_dst;
                        part_src_imm <= 16'h0000;
                        if (word_has_src) begin
                            state <= SRC_IMM;
                        end else if (word_has_dst) begin
                            state <= DST_IMM;
                        end else begin
                            exe_valid_o         <= 1'b1;
                            exe_inst_o          <= fetch_inst_i;
                            exe_addr_o          <= fetch_addr_i;
                            exe_src_imm_o       <= 16'h0000;
                            exe_dst_imm_o       <= 16'h0000;
                            exe_src_imm_valid_o <= 1'b0;
                            exe_dst_imm_valid_o <= 1'b0;
                        end
                    end
                    SRC_IMM: if (accept) begin
                        part_src_imm <= fetch_inst_i;
                        if (part_has_dst) begin
                            state <= DST_IMM;
                        end else begin
                            state               <= OPCODE;
                            exe_valid_o         <= 1'b1;
                            exe_inst_o          <= part_inst;
                            exe_addr_o          <= part_addr;
                            exe_src_imm_o       <= fetch_inst_i;
                            exe_dst_imm_o       <= 16'h0000;
                            exe_src_imm_valid_o <= 1'b1;
                            exe_dst_imm_valid_o <= 1'b0;
                        end
                    end
                    DST_IMM: if (accept) begin
                        state               <= OPCODE;
                        exe_valid_o         <= 1'b1;
                        exe_inst_o          <= part_inst;
                        exe_addr_o          <= part_addr;
                        exe_src_imm_o       <= part_src_imm;
                        exe_dst_imm_o       <= fetch_inst_i;
                        exe_src_imm_valid_o <= part_has_src;
                        exe_dst_imm_valid_o <= 1'b1;
                    end
                    default: state <= START;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_decode_collect.sv
// tb_decode_collect: directed and randomized checks of decode_collect against
// a word-grouping reference model.
`timescale 1ns/1ps
module tb_decode_collect;

    localparam logic [15:0] RESET_PC = 16'h0100;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        fetch_valid;
    logic        fetch_ready;
    logic [15:0] fetch_addr;
    logic [15:0] fetch_inst;
    logic        fetch_pc_valid;
    logic [15:0] fetch_pc;
    logic        exe_valid;
    logic        exe_ready;
    logic [15:0] exe_addr;
    logic [15:0] exe_inst;
    logic [15:0] exe_src_imm;
    logic [15:0] exe_dst_imm;
    logic        exe_src_imm_valid;
    logic        exe_dst_imm_valid;
    logic        branch_valid;
    logic [15:0] branch_pc;

    always #5 clk = ~clk;

    decode_collect #(.RESET_PC(RESET_PC)) dut (
        .clk_i               (clk),
        .rst_n_i             (rst_n),
        .fetch_valid_i       (fetch_valid),
        .fetch_ready_o       (fetch_ready),
        .fetch_addr_i        (fetch_addr),
        .fetch_inst_i        (fetch_inst),
        .fetch_pc_valid_o    (fetch_pc_valid),
        .fetch_pc_o          (fetch_pc),
        .exe_valid_o         (exe_valid),
        .exe_ready_i         (exe_ready),
        .exe_addr_o          (exe_addr),
        .exe_inst_o          (exe_inst),
        .exe_src_imm_o       (exe_src_imm),
        .exe_dst_imm_o       (exe_dst_imm),
        .exe_src_imm_valid_o (exe_src_imm_valid),
        .exe_dst_imm_valid_o (exe_dst_imm_valid),
        .exe_branch_valid_i  (branch_valid),
        .exe_branch_pc_i     (branch_pc)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference model: expected output register and the words of the
    // instruction being collected.
    logic        m_start, m_valid, m_pcv, m_siv, m_div;
    logic [15:0] m_pc, m_inst, m_addr, m_si, m_di;
    logic [15:0] pw[$];
    logic [15:0] pa;

    function automatic int words_needed(input logic [15:0] w);
        int n = 1;
        if (w[11:8] == 4'hF && w[7:6] == 2'd2) n++;
        if (w[5:2] == 4'hF && w[1:0] == 2'd2 && w[15:12] != 4'hE && w[15:12] != 4'hF) n++;
        return n;
    endfunction

    task automatic model_reset();
        m_start = 1'b1; m_valid = 1'b0; m_pcv = 1'b0; m_pc = 16'h0;
        m_siv = 1'b0; m_div = 1'b0;
        m_inst = 16'h0; m_addr = 16'h0; m_si = 16'h0; m_di = 16'h0;
        pw.delete();
    endtask

    // Called at posedge+1: drive, check at negedge, advance model, return at posedge+1.
    task automatic cyc(input logic v, input logic [15:0] a, input logic [15:0] w,
                       input logic rdy, input logic br, input logic [15:0] bpc);
        logic exp_rdy;
        logic acc;
        logic take;
        fetch_valid = v; fetch_addr = a; fetch_inst = w;
        exe_ready = rdy; branch_valid = br; branch_pc = bpc;
        @(negedge clk);
        check("exe_valid", {31'd0, exe_valid}, {31'd0, m_valid});
        if (m_valid) begin
            check("exe_inst", {16'd0, exe_inst}, {16'd0, m_inst});
            check("exe_addr", {16'd0, exe_addr}, {16'd0, m_addr});
            check("src_imm", {15'd0, exe_src_imm_valid, exe_src_imm}, {15'd0, m_siv, m_si});
            check("dst_imm", {15'd0, exe_dst_imm_valid, exe_dst_imm}, {15'd0, m_div, m_di});
        end
        check("pc_valid", {31'd0, fetch_pc_valid}, {31'd0, m_start || m_pcv});
        if (m_start || m_pcv)
            check("pc", {16'd0, fetch_pc}, {16'd0, m_start ? RESET_PC : m_pc});
        if (m_start) exp_rdy = 1'b0;
        else begin
            int need;
            need = (pw.size() == 0) ? words_needed(w) : words_needed(pw[0]);
            exp_rdy = !((pw.size() + 1 == need) && m_valid && !rdy);
        end
        check("fetch_ready", {31'd0, fetch_ready}, {31'd0, exp_rdy});

        acc  = v && fetch_ready;
        take = m_valid && rdy;
        m_start = 1'b0;
        m_pcv   = br;
        if (br) m_pc = bpc;
        if (br) begin
            pw.delete();
            m_valid = 1'b0;
        end else begin
            logic done = 1'b0;
            if (acc) begin
                if (pw.size() == 0) pa = a;
                pw.push_back(w);
                if (pw.size() == words_needed(pw[0])) begin
                    m_inst = pw[0];
                    m_addr = pa;
                    m_siv  = (pw[0][11:8] == 4'hF && pw[0][7:6] == 2'd2);
                    m_div  = (pw.size() == 3) || (pw.size() == 2 && !m_siv);
                    m_si   = m_siv ? pw[1] : 16'h0;
                    m_di   = m_div ? pw[pw.size() - 1] : 16'h0;
                    pw.delete();
                    done = 1'b1;
                end
            end
            if (done) m_valid = 1'b1;
            else if (take) m_valid = 1'b0;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        fetch_valid = 1'b0; fetch_addr = 16'h0; fetch_inst = 16'h0;
        exe_ready = 1'b1; branch_valid = 1'b0; branch_pc = 16'h0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_reset();
    endtask

    initial begin
        do_reset();
        // Reset-release START cycle
        cyc(1'b0, 16'h0, 16'h0, 1'b1, 1'b0, 16'h0);
        check("start_gone", {31'd0, fetch_pc_valid}, 32'd0);

        // Single-word instruction
        cyc(1'b1, 16'h0010, 16'h1234, 1'b1, 1'b0, 16'h0);
        check("d1_valid", {31'd0, exe_valid}, 32'd1);
        check("d1_inst", {16'd0, exe_inst}, 32'h1234);
        check("d1_addr", {16'd0, exe_addr}, 32'h0010);
        check("d1_immv", {30'd0, exe_src_imm_valid, exe_dst_imm_valid}, 32'd0);

        // Both immediates
        cyc(1'b1, 16'h0020, 16'h0FBE, 1'b1, 1'b0, 16'h0);
        cyc(1'b1, 16'h0021, 16'h1111, 1'b1, 1'b0, 16'h0);
        cyc(1'b1, 16'h0022, 16'h2222, 1'b1, 1'b0, 16'h0);
        check("d2_inst", {16'd0, exe_inst}, 32'h0FBE);
        check("d2_addr", {16'd0, exe_addr}, 32'h0020);
        check("d2_src", {15'd0, exe_src_imm_valid, exe_src_imm}, {15'd0, 1'b1, 16'h1111});
        check("d2_dst", {15'd0, exe_dst_imm_valid, exe_dst_imm}, {15'd0, 1'b1, 16'h2222});

        // Opcode 0xF suppresses the destination immediate
        cyc(1'b1, 16'h0030, 16'hFFBE, 1'b1, 1'b0, 16'h0);
        cyc(1'b1, 16'h0031, 16'h3333, 1'b1, 1'b0, 16'h0);
        check("d3_src", {15'd0, exe_src_imm_valid, exe_src_imm}, {15'd0, 1'b1, 16'h3333});
        check("d3_dstv", {15'd0, exe_dst_imm_valid, exe_dst_imm}, 32'd0);
        cyc(1'b1, 16'h0032, 16'h1234, 1'b1, 1'b0, 16'h0);
        check("d3_next", {16'd0, exe_inst}, 32'h1234);

        // Back-pressure with a stream of single-word instructions
        for (int i = 0; i < 3; i++) cyc(1'b1, 16'h0040 + 16'(i), 16'h1234, 1'b0, 1'b0, 16'h0);
        for (int i = 0; i < 3; i++) cyc(1'b1, 16'h0050 + 16'(i), 16'h1234, 1'b1, 1'b0, 16'h0);

        // Branch while collecting the source immediate
        cyc(1'b1, 16'h0060, 16'h0FBE, 1'b1, 1'b0, 16'h0);
        cyc(1'b1, 16'h0061, 16'h1111, 1'b1, 1'b1, 16'h0400);
        check("br_pcv", {31'd0, fetch_pc_valid}, 32'd1);
        check("br_pc", {16'd0, fetch_pc}, 32'h0400);
        check("br_valid", {31'd0, exe_valid}, 32'd0);
        cyc(1'b1, 16'h0400, 16'h1234, 1'b1, 1'b0, 16'h0);
        check("br_next", {16'd0, exe_inst}, 32'h1234);
        check("br_addr", {16'd0, exe_addr}, 32'h0400);

        // Reset mid-DST_IMM takes effect without a clock edge
        cyc(1'b1, 16'h0070, 16'h0FBE, 1'b1, 1'b0, 16'h0);
        cyc(1'b1, 16'h0071, 16'h1111, 1'b1, 1'b0, 16'h0);
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_flags", {28'd0, exe_valid, fetch_ready, fetch_pc_valid,
                            exe_src_imm_valid | exe_dst_imm_valid}, 32'd0);
        check("rst_inst_addr", {exe_inst, exe_addr}, 32'd0);
        check("rst_imm", {exe_src_imm, exe_dst_imm}, 32'd0);
        check("rst_pc", {16'd0, fetch_pc}, 32'd0);
        do_reset();

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            logic [15:0] w;
            w = 16'($urandom);
            if ($urandom_range(0, 2) == 0) w[7:6] = 2'd2;
            if ($urandom_range(0, 1) == 0) w[11:8] = 4'hF;
            if ($urandom_range(0, 2) == 0) w[1:0] = 2'd2;
            if ($urandom_range(0, 1) == 0) w[5:2] = 4'hF;
            cyc($urandom_range(0, 4) != 0, 16'($urandom), w,
                $urandom_range(0, 9) < 7, $urandom_range(0, 24) == 0, 16'($urandom));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/decode_collect.md
DECODE_COLLECT -- requirements
Module: decode_collect

Interface
REQ-001 SHALL have parameter RESET_PC, default 16'h0000, meaning the program counter sent to fetch after reset.
REQ-002 SHALL have port clk_i  in  1  rising-edge clock; the only clock.
REQ-003 SHALL have port rst_n_i  in  1  reset, asynchronous assert, active-low.
REQ-004 SHALL have port fetch_valid_i  in  1  fetch word valid.
REQ-005 SHALL have port fetch_ready_o  out  1  word accepted when high with fetch_valid_i.
REQ-006 SHALL have port fetch_addr_i  in  16  address of fetched word.
REQ-007 SHALL have port fetch_inst_i  in  16  fetched word.
REQ-008 SHALL have port fetch_pc_valid_o  out  1  one-cycle pulse: fetch restarts at fetch_pc_o.
REQ-009 SHALL have port fetch_pc_o  out  16  restart address.
REQ-010 SHALL have port exe_valid_o  out  1  complete instruction valid.
REQ-011 SHALL have port exe_ready_i  in  1  execute accepts instruction.
REQ-012 SHALL have port exe_addr_o, exe_inst_o  out  16 each  address and opcode word of the instruction.
REQ-013 SHALL have port exe_src_imm_o, exe_dst_imm_o  out  16 each  immediate operands.
REQ-014 SHALL have port exe_src_imm_valid_o, exe_dst_imm_valid_o  out  1 each  immediate present.
REQ-015 SHALL have port exe_branch_valid_i  in  1  execute redirect request.
REQ-016 SHALL have port exe_branch_pc_i  in  16  redirect target.

Function
REQ-017 Opcode word fields SHALL be: opcode [15:12], src reg [11:8], src mode [7:6], dst reg [5:2], dst mode [1:0].
REQ-018 Src immediate SHALL follow iff src reg = 15 and src mode = 2; dst immediate SHALL follow iff dst reg = 15, dst mode = 2 and opcode not in {0xE, 0xF}; when both, src word precedes dst word.
REQ-019 States SHALL be: START, OPCODE, SRC_IMM, DST_IMM; separately an output register holds exe_* plus exe_valid_o.
REQ-020 START (entered by reset) SHALL last one cycle, driving fetch_pc_valid_o=1, fetch_pc_o=RESET_PC, fetch_ready_o=0, then go to OPCODE.
REQ-021 OPCODE: accepted word SHALL be latched as exe_inst_o/exe_addr_o; next state SRC_IMM, DST_IMM or (no immediates) OPCODE with instruction complete.
REQ-022 SRC_IMM: accepted word SHALL be latched as exe_src_imm_o; next DST_IMM if dst immediate else OPCODE with instruction complete.
REQ-023 DST_IMM: accepted word SHALL be latched as exe_dst_imm_o; next OPCODE with instruction complete.
REQ-024 Completion SHALL set exe_valid_o the next cycle (single-word latency 1 cycle), with imm valid flags per REQ-018; throughput one instruction per cycle.
REQ-025 fetch_ready_o SHALL be high in OPCODE/SRC_IMM/DST_IMM except when the accepted word would complete an instruction while exe_valid_o=1 and exe_ready_i=0.
REQ-026 While exe_valid_o=1 and exe_ready_i=0, all exe_* outputs SHALL be stable.
REQ-027 exe_valid_o SHALL clear after handshake unless a new instruction completes in the same cycle.
REQ-028 exe_branch_valid_i=1 SHALL, next cycle: pulse fetch_pc_valid_o with fetch_pc_o=exe_branch_pc_i, clear exe_valid_o, discard partial instruction, return to OPCODE; any word accepted in the branch cycle is discarded; branch has priority over all other events.
REQ-029 fetch_pc_valid_o SHALL be high only in START or the cycle after a branch.
REQ-030 Immediate outputs whose valid flag is 0 SHALL read 16'h0000.

Reset
REQ-031 rst_n_i low SHALL immediately set state START, exe_valid_o=0, fetch_ready_o=0, fetch_pc_valid_o=0, all 16-bit outputs 0, and discard any partial instruction.
REQ-032 First cycle after rst_n_i rises SHALL be START per REQ-020.

Verification
REQ-033 Release reset, RESET_PC=16'h0100 -> fetch_pc_valid_o=1 one cycle, fetch_pc_o=16'h0100, exe_valid_o=0.
REQ-034 Word 16'h1234 at 16'h0010 -> next cycle exe_valid_o=1, exe_inst_o=16'h1234, exe_addr_o=16'h0010, both imm valid 0.
REQ-035 Words 16'h0FBE, 16'h1111, 16'h2222 from 16'h0020 -> one instruction, src_imm=16'h1111, dst_imm=16'h2222, both valid, addr 16'h0020.
REQ-036 Word 16'hFFBE then 16'h3333 -> src_imm=16'h3333 valid, dst_imm_valid=0; next word decoded as opcode.
REQ-037 exe_ready_i low 3 cycles with stream of 16'h1234 -> exe_* stable, fetch_ready_o low at completion, no word lost or duplicated.
REQ-038 exe_branch_valid_i=1, exe_branch_pc_i=16'h0400 while in SRC_IMM -> fetch_pc_valid_o pulse with 16'h0400, partial dropped, next word decoded as opcode; rst_n_i low mid-DST_IMM -> REQ-031 values immediately.
